// File: rtl/pixel_input_port_if.sv
// Bus and stream signals of the pixel input port: processor read bus plus the
// upstream pixel valid/ready stream.
interface pixel_input_port_if;
  // Processor read bus
  logic       rden;
  logic [7:0] IRAM_address;
  logic [7:0] rdata;

  // Pixel stream: a transfer happens on a posedge where in_valid && in_ready.
  // The source holds in_data stable while in_valid is high and in_ready is low.
  logic       in_valid;
  logic [7:0] in_data;
  logic       in_ready;

  modport master (
    output rden,
    output IRAM_address,
    input  rdata,
    output in_valid,
    output in_data,
    input  in_ready
  );

  modport slave (
    input  rden,
    input  IRAM_address,
    output rdata,
    input  in_valid,
    input  in_data,
    output in_ready
  );
endinterface

// File: rtl/pixel_input_port.sv
// Memory-mapped pixel input port: a FIFO filled from a valid/ready stream and
// drained by processor reads of DATA_ADDR, with a status byte at STATUS_ADDR.
module pixel_input_port #(
  parameter logic [7:0] DATA_ADDR   = 8'd80,
  parameter logic [7:0] STATUS_ADDR = 8'd81,
  parameter int         DEPTH       = 16,
  parameter int         CW          = 5
) (
  input  logic                clock,
  input  logic                reset_n,
  pixel_input_port_if.slave   bus,
  output logic [CW-1:0]       fifo_count,
  output logic                underflow,
  output logic [15:0]         pix_count
);

  localparam int AW = CW - 1;

  logic [7:0]    mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q,  count_d;
  logic [7:0]    rdata_q,  rdata_d;
  logic          underflow_q, underflow_d;
  logic [15:0]   pix_q,    pix_d;

  logic push, pop_req, pop_ok, stat_req, not_full;

  assign not_full = (count_q != CW'(DEPTH));
  assign push     = bus.in_valid && not_full;
  assign pop_req  = bus.rden && (bus.IRAM_address == DATA_ADDR);
  assign stat_req = bus.rden && (bus.IRAM_address == STATUS_ADDR);
  assign pop_ok   = pop_req && (count_q != '0);

  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    rdata_d     = rdata_q;
    underflow_d = underflow_q;
    pix_d       = pix_q;

    // Pointers are AW bits wide, so natural overflow gives the modulo-DEPTH wrap.
    if (push) begin
      wr_ptr_d = wr_ptr_q + 1'b1;
    end

    if (pop_ok) begin
      rdata_d  = mem_q[rd_ptr_q];
      rd_ptr_d = rd_ptr_q + 1'b1;
      pix_d    = pix_q + 16'd1;
    end else if (pop_req) begin
      rdata_d     = 8'h00;
      underflow_d = 1'b1;
    end else if (stat_req) begin
      rdata_d     = {underflow_q, 7'(count_q)};
      underflow_d = 1'b0;
    end

    case ({push, pop_ok})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      rdata_q     <= 8'h00;
      underflow_q <= 1'b0;
      pix_q       <= 16'd0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      rdata_q     <= rdata_d;
      underflow_q <= underflow_d;
      pix_q       <= pix_d;
    end
  end

  // Storage needs no reset: entries are only visible through the reset pointers.
  always_ff @(posedge clock) begin
    if (push) begin
      mem_q[wr_ptr_q] <= bus.in_data;
    end
  end

  assign bus.rdata    = rdata_q;
  assign bus.in_ready = not_full;
  assign fifo_count   = count_q;
  assign underflow    = underflow_q;
  assign pix_count    = pix_q;

endmodule

// File: tb/tb_pixel_input_port.sv
// Directed bench for pixel_input_port: vector table plus hand-written
// full/stream/reset sequences, checked at the negedge after each request.
module tb_pixel_input_port;

  localparam int DEPTH = 16;
  localparam int CW    = 5;

  logic          clock;
  logic          reset_n;
  logic [CW-1:0] fifo_count;
  logic          underflow;
  logic [15:0]   pix_count;

  int checks = 0;
  int errors = 0;

  logic [7:0] exp_q[$];

  pixel_input_port_if bus ();

  pixel_input_port #(
    .DATA_ADDR  (8'd80),
    .STATUS_ADDR(8'd81),
    .DEPTH      (DEPTH),
    .CW         (CW)
  ) dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .bus       (bus.slave),
    .fifo_count(fifo_count),
    .underflow (underflow),
    .pix_count (pix_count)
  );

  // Clock / reset
  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  typedef struct {
    logic       rden;
    logic [7:0] addr;
    logic       valid;
    logic [7:0] data;
    logic [7:0] e_rdata;
    int         e_count;
    logic       e_uf;
    int         e_pix;
    logic       e_ready;
  } vec_t;

  vec_t vecs[16];

  task automatic check(input string name, input int actual, input int expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic drive(input logic r, input logic [7:0] a, input logic v, input logic [7:0] d);
    bus.rden         = r;
    bus.IRAM_address = a;
    bus.in_valid     = v;
    bus.in_data      = d;
  endtask

  task automatic step(input logic r, input logic [7:0] a, input logic v, input logic [7:0] d);
    drive(r, a, v, d);
    @(negedge clock);
  endtask

  initial begin
    logic [7:0] d;
    int         got;

    //          rden addr   vld data   rdata  cnt uf pix rdy
    vecs[0]  = '{0, 8'd0,  1, 8'h11, 8'h00, 1, 0, 0, 1};
    vecs[1]  = '{0, 8'd0,  1, 8'h22, 8'h00, 2, 0, 0, 1};
    vecs[2]  = '{0, 8'd0,  1, 8'h33, 8'h00, 3, 0, 0, 1};
    vecs[3]  = '{1, 8'd80, 0, 8'h00, 8'h11, 2, 0, 1, 1};
    vecs[4]  = '{1, 8'd80, 0, 8'h00, 8'h22, 1, 0, 2, 1};
    vecs[5]  = '{1, 8'd80, 0, 8'h00, 8'h33, 0, 0, 3, 1};
    vecs[6]  = '{1, 8'd80, 0, 8'h00, 8'h00, 0, 1, 3, 1};
    vecs[7]  = '{1, 8'd81, 0, 8'h00, 8'h80, 0, 0, 3, 1};
    vecs[8]  = '{1, 8'd81, 0, 8'h00, 8'h00, 0, 0, 3, 1};
    vecs[9]  = '{1, 8'd80, 1, 8'h44, 8'h00, 1, 1, 3, 1};
    vecs[10] = '{1, 8'd81, 0, 8'h00, 8'h81, 1, 0, 3, 1};
    vecs[11] = '{1, 8'd79, 0, 8'h00, 8'h81, 1, 0, 3, 1};
    vecs[12] = '{1, 8'd82, 0, 8'h00, 8'h81, 1, 0, 3, 1};
    vecs[13] = '{0, 8'd80, 0, 8'h00, 8'h81, 1, 0, 3, 1};
    vecs[14] = '{1, 8'd80, 1, 8'h55, 8'h44, 1, 0, 4, 1};
    vecs[15] = '{1, 8'd80, 0, 8'h00, 8'h55, 0, 0, 5, 1};

    reset_n = 1'b0;
    drive(0, 8'd0, 0, 8'h00);
    repeat (2) @(negedge clock);
    check("reset_rdata", bus.rdata, 0);
    check("reset_count", fifo_count, 0);
    check("reset_uf", underflow, 0);
    check("reset_pix", pix_count, 0);
    reset_n = 1'b1;
    @(negedge clock);
    check("ready_after_reset", bus.in_ready, 1);

    // Table-driven vectors
    for (int i = 0; i < 16; i++) begin
      step(vecs[i].rden, vecs[i].addr, vecs[i].valid, vecs[i].data);
      check($sformatf("v%0d_rdata", i), bus.rdata, vecs[i].e_rdata);
      check($sformatf("v%0d_count", i), fifo_count, vecs[i].e_count);
      check($sformatf("v%0d_uf", i), underflow, vecs[i].e_uf);
      check($sformatf("v%0d_pix", i), pix_count, vecs[i].e_pix);
      check($sformatf("v%0d_ready", i), bus.in_ready, vecs[i].e_ready);
    end

    // Full FIFO: back-pressure, then a pop reopens exactly one slot
    for (int i = 0; i < DEPTH; i++) begin
      step(0, 8'd0, 1, 8'(i));
      exp_q.push_back(8'(i));
    end
    check("full_count", fifo_count, DEPTH);
    check("full_ready", bus.in_ready, 0);
    step(0, 8'd0, 1, 8'hAA);
    check("held_count", fifo_count, DEPTH);
    step(1, 8'd80, 1, 8'hAA);
    check("full_pop_rdata", bus.rdata, exp_q.pop_front());
    check("full_pop_count", fifo_count, DEPTH - 1);
    check("full_pop_ready", bus.in_ready, 1);
    step(0, 8'd0, 1, 8'hAA);
    exp_q.push_back(8'hAA);
    check("refill_count", fifo_count, DEPTH);
    check("refill_ready", bus.in_ready, 0);
    for (int i = 0; i < DEPTH; i++) begin
      step(1, 8'd80, 0, 8'h00);
      got = exp_q.pop_front();
      check($sformatf("drain%0d", i), bus.rdata, got);
    end
    check("drain_count", fifo_count, 0);
    check("drain_pix", pix_count, 22);

    // Streaming with 2-cycle pop lag: pointers wrap, occupancy steady at 2
    for (int k = 0; k < 42; k++) begin
      d = 8'(k * 7 + 3);
      if (k < 40) exp_q.push_back(d);
      step(k >= 2, 8'd80, k < 40, d);
      if (k >= 2) begin
        got = exp_q.pop_front();
        check($sformatf("stream%0d", k), bus.rdata, got);
      end
      if (k >= 1 && k < 40) check($sformatf("stream_cnt%0d", k), fifo_count, 2);
    end
    check("stream_end_count", fifo_count, 0);
    check("stream_pix", pix_count, 62);

    // Asynchronous reset mid-stream
    step(1, 8'd80, 0, 8'h00);
    check("pre_rst_uf", underflow, 1);
    for (int i = 0; i < 5; i++) step(0, 8'd0, 1, 8'(8'hC0 + i));
    step(1, 8'd80, 0, 8'h00);
    check("pre_rst_rdata", bus.rdata, 8'hC0);
    check("pre_rst_count", fifo_count, 4);
    #2 reset_n = 1'b0;
    #1;
    check("async_count", fifo_count, 0);
    check("async_rdata", bus.rdata, 0);
    check("async_uf", underflow, 0);
    check("async_pix", pix_count, 0);
    check("async_ready", bus.in_ready, 1);
    @(negedge clock);
    reset_n = 1'b1;
    step(1, 8'd80, 0, 8'h00);
    check("post_rst_rdata", bus.rdata, 0);
    check("post_rst_uf", underflow, 1);
    check("post_rst_count", fifo_count, 0);
    check("post_rst_pix", pix_count, 0);

    drive(0, 8'd0, 0, 8'h00);
    @(negedge clock);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pixel_input_port.md
Name: pixel_input_port

Overview:
- Memory-mapped input port: the read-side counterpart of the processor's output-data capture port.
- An external source (testbench file reader or upstream image loader) streams 8-bit pixels over a valid/ready handshake into an internal FIFO.
- The processor pops pixels by reading DATA_ADDR, and polls FIFO occupancy and underflow by reading STATUS_ADDR.
- Sits beside the data memory on the processor's address/read-enable bus.

Parameters:
- DATA_ADDR, 80: address whose read pops one pixel.
- STATUS_ADDR, 81: address whose read returns the status byte.
- DEPTH, 16: FIFO entries; power of two, 2..64.
- CW, 5: count width, log2(DEPTH)+1.

Ports:
- clock  in  1  system clock; all state updates on posedge.
- reset_n  in  1  asynchronous, active-low reset.
- rden  in  1  processor read enable.
- IRAM_address  in  8  processor address bus.
- rdata  out  8  read data, registered.
- in_valid  in  1  source has a pixel on in_data.
- in_data  in  8  source pixel.
- in_ready  out  1  FIFO can accept a pixel.
- fifo_count  out  CW  current occupancy, 0..DEPTH.
- underflow  out  1  sticky: a pop was attempted while empty.
- pix_count  out  16  total pixels successfully popped since reset.

Behaviour:
- Reset (reset_n low, asynchronous):
  - rdata=0, fifo_count=0, underflow=0, pix_count=0.
  - Read/write pointers = 0.
  - in_ready=1 the cycle after release.
  - Reset mid-stream discards all FIFO contents.
- in_ready = (fifo_count != DEPTH); combinational from registered count.
- Push: in_valid && in_ready at posedge.
  - Stores in_data at wr_ptr; wr_ptr increments modulo DEPTH (wraps DEPTH-1 -> 0).
- Pop request: rden && IRAM_address==DATA_ADDR.
  - If fifo_count>0: rdata <= mem[rd_ptr]; rd_ptr increments modulo DEPTH; pix_count increments (wraps 0xFFFF -> 0).
  - If fifo_count==0: rdata <= 0; underflow <= 1; no pointer, count or pix_count change.
- Status read: rden && IRAM_address==STATUS_ADDR.
  - rdata <= {underflow, fifo_count zero-extended/truncated to 7 bits}.
  - underflow is cleared in the same cycle.
  - If an underflow event and a status read coincide, the status read wins (they cannot coincide: both need rden with different addresses).
- Any other address, or rden=0: rdata holds its value; no side effects.
- Read latency: rdata is valid on the posedge following the request. It stays stable through the following negedge, when the processor samples it.
- fifo_count:
  - +1 on push only.
  - -1 on successful pop only.
  - Unchanged on simultaneous push and successful pop.
- Full with pop in the same cycle: in_ready was already low, so no push occurs that cycle. The count drops to DEPTH-1 and in_ready rises the next cycle.
- Empty with push and pop in the same cycle: the pop underflows (returns 0, sets underflow). The pushed pixel is stored and count becomes 1. No bypass from in_data to rdata.
- in_data is sampled only on push; the source holds in_data while in_valid && !in_ready.

Test Plan:
- Reset, then push 3 pixels (0x11,0x22,0x33); read DATA_ADDR three times -> rdata 0x11,0x22,0x33 one cycle after each read; pix_count=3, fifo_count=0.
- Push 16 pixels 0..15 -> in_ready low after the 16th; hold in_valid with 0xAA -> no push. Pop once -> rdata=0, in_ready high next cycle, 0xAA accepted, fifo_count=16.
- Empty FIFO, read DATA_ADDR -> rdata=0, underflow=1, pix_count unchanged. Read STATUS_ADDR -> rdata=0x80, underflow=0 next cycle.
- Push 40 pixels, popping one per cycle with a 2-cycle start lag -> pointers wrap twice; output sequence equals input sequence; fifo_count steady at 2.
- Fill 5 entries, assert reset_n low mid-cycle -> fifo_count=0, rdata=0, underflow=0 immediately (asynchronous); next DATA_ADDR read underflows.
- Read address 79 and 82 with rden=1 -> rdata unchanged, no count change.
